// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding, SPI register map and timer sizing helper
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    localparam logic [2:0] ADDR_CR1 = 3'b000;
    localparam logic [2:0] ADDR_CR2 = 3'b001;
    localparam logic [2:0] ADDR_BR  = 3'b010;
    localparam logic [2:0] ADDR_SR  = 3'b011;
    localparam logic [2:0] ADDR_DR  = 3'b101;

    // A disabled timer (timeout 0) still gets a 1-bit counter so widths stay legal.
    function automatic int timer_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - ACCESS wait-state counter with clear, count enable and expiry flag
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic Pclk,
    input  logic Preset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int              CW      = timer_width(TIMEOUT);
    localparam bit              ENABLED = (TIMEOUT > 0);
    localparam logic [CW-1:0]   LAST    = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    // Expiry is combinational so the abort lands in the same cycle the limit is reached.
    assign expired = ENABLED && count_en && (count == LAST);

    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (ENABLED && count_en && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - command/response to APB requester with wait-state timeout
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              Pclk,
    input  logic              Preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_t        state, state_d;
    logic              psel_d, penable_d, pwrite_d, busy_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d, rdata_d;
    logic              rsp_valid_d, err_d, to_d;
    logic              complete, accept, expired;

    assign complete  = (state == ACCESS) && PREADY;
    assign cmd_ready = (state == IDLE) || complete;
    assign accept    = cmd_valid && cmd_ready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .Pclk     (Pclk),
        .Preset   (Preset),
        .clear    (state_d == SETUP),
        .count_en ((state == ACCESS) && !PREADY),
        .expired  (expired)
    );

    always_comb begin
        state_d     = state;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        rsp_valid_d = 1'b0;
        rdata_d     = rsp_rdata;
        err_d       = rsp_err;
        to_d        = rsp_timeout;

        case (state)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // PREADY is checked first so a completion in the expiry cycle wins.
                if (PREADY) begin
                    rsp_valid_d = 1'b1;
                    err_d       = PSLVERR;
                    to_d        = 1'b0;
                    rdata_d     = (!PWRITE && !PSLVERR) ? PRDATA : '0;
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                end else if (expired) begin
                    rsp_valid_d = 1'b1;
                    err_d       = 1'b1;
                    to_d        = 1'b1;
                    rdata_d     = '0;
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // A command taken at completion chains straight into SETUP, keeping PSEL high.
        if (accept) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_wdata;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            PWRITE      <= pwrite_d;
            PADDR       <= paddr_d;
            PWDATA      <= pwdata_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rdata_d;
            rsp_err     <= err_d;
            rsp_timeout <= to_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master with a behavioural SPI APB slave
module tb_apb_master;

    localparam int TO = 4;

    logic       Pclk = 1'b0;
    logic       Preset = 1'b1;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [2:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
    logic [7:0] rsp_rdata;
    logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [2:0] PADDR;
    logic [7:0] PWDATA, PRDATA;

    logic       t3_cmd_valid = 1'b0, t3_cmd_write = 1'b0;
    logic [2:0] t3_cmd_addr = '0;
    logic [7:0] t3_cmd_wdata = '0;
    logic       t3_cmd_ready, t3_rsp_valid, t3_rsp_err, t3_rsp_timeout, t3_busy;
    logic [7:0] t3_rsp_rdata;
    logic       t3_psel, t3_penable, t3_pwrite;
    logic [2:0] t3_paddr;
    logic [7:0] t3_pwdata;
    logic [7:0] t3_prdata = '0;
    logic       t3_pready = 1'b0, t3_pslverr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 Pclk = ~Pclk;

    apb_master #(.ADDR_W(3), .DATA_W(8), .TIMEOUT(TO)) dut (
        .Pclk(Pclk), .Preset(Preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_master #(.ADDR_W(3), .DATA_W(8), .TIMEOUT(3)) u_t3 (
        .Pclk(Pclk), .Preset(Preset),
        .cmd_valid(t3_cmd_valid), .cmd_ready(t3_cmd_ready), .cmd_write(t3_cmd_write),
        .cmd_addr(t3_cmd_addr), .cmd_wdata(t3_cmd_wdata),
        .rsp_valid(t3_rsp_valid), .rsp_rdata(t3_rsp_rdata), .rsp_err(t3_rsp_err),
        .rsp_timeout(t3_rsp_timeout), .busy(t3_busy),
        .PSEL(t3_psel), .PENABLE(t3_penable), .PWRITE(t3_pwrite), .PADDR(t3_paddr),
        .PWDATA(t3_pwdata), .PRDATA(t3_prdata), .PREADY(t3_pready), .PSLVERR(t3_pslverr)
    );

    // SPI slave: slv_waits wait states, PSLVERR on DR while a transfer is in progress.
    logic [7:0] slv_mem [8];
    int         slv_waits = 0;
    bit         slv_tip = 1'b0;
    int         acc_cnt;

    assign PREADY  = PSEL && PENABLE && (acc_cnt >= slv_waits);
    assign PSLVERR = PSEL && PENABLE && slv_tip && (PADDR == apb_pkg::ADDR_DR);
    assign PRDATA  = slv_mem[PADDR];

    always @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            acc_cnt <= 0;
            for (int i = 0; i < 8; i++) slv_mem[i] <= 8'h00;
        end else begin
            acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
            if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) slv_mem[PADDR] <= PWDATA;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_cmd(input string nm, input bit w, input logic [2:0] a, input logic [7:0] d,
                           input int wt, input bit tp, input logic [7:0] e_rd, input bit e_err,
                           input bit e_to, input int e_lat);
        int cyc = 0;
        int acc = 0;
        bit seen = 1'b0;
        slv_waits = wt;
        slv_tip   = tp;
        @(negedge Pclk);
        check({nm, ".ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(posedge Pclk);
        #1 cmd_valid = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge Pclk);
            cyc++;
            if (PSEL && PENABLE) acc++;
            if (rsp_valid) seen = 1'b1;
        end
        check({nm, ".lat"}, 32'(cyc), 32'(e_lat));
        check({nm, ".acc"}, 32'(acc), 32'(e_lat - 2));
        check({nm, ".rsp"}, {21'd0, rsp_err, rsp_timeout, rsp_rdata, PSEL},
              {21'd0, e_err, e_to, e_rd, 1'b0});
        @(negedge Pclk);
        check({nm, ".pulse"}, {22'd0, rsp_valid, rsp_err, rsp_rdata}, {22'd0, 1'b0, e_err, e_rd});
    endtask

    typedef struct {
        bit         w;
        logic [2:0] a;
        logic [7:0] d;
        int         wt;
        bit         tp;
        logic [7:0] rd;
        bit         err;
        bit         to;
        int         lat;
    } vec_t;

    vec_t       tbl [12];
    logic [7:0] ref_mem [8];
    logic [2:0] addr_set [5];
    logic [4:0] tr_exp [4];

    initial begin
        tbl[0]  = '{1'b1, apb_pkg::ADDR_CR1, 8'h5C, 1,   1'b0, 8'h00, 1'b0, 1'b0, 4};
        tbl[1]  = '{1'b0, apb_pkg::ADDR_CR1, 8'h00, 1,   1'b0, 8'h5C, 1'b0, 1'b0, 4};
        tbl[2]  = '{1'b1, apb_pkg::ADDR_DR,  8'h9E, 1,   1'b0, 8'h00, 1'b0, 1'b0, 4};
        tbl[3]  = '{1'b0, apb_pkg::ADDR_DR,  8'h00, 1,   1'b1, 8'h00, 1'b1, 1'b0, 4};
        tbl[4]  = '{1'b1, apb_pkg::ADDR_BR,  8'hA3, 0,   1'b0, 8'h00, 1'b0, 1'b0, 3};
        tbl[5]  = '{1'b0, apb_pkg::ADDR_BR,  8'h00, 2,   1'b0, 8'hA3, 1'b0, 1'b0, 5};
        tbl[6]  = '{1'b0, apb_pkg::ADDR_BR,  8'h00, 100, 1'b0, 8'h00, 1'b1, 1'b1, 6};
        tbl[7]  = '{1'b0, apb_pkg::ADDR_BR,  8'h00, 3,   1'b0, 8'hA3, 1'b0, 1'b0, 6};
        tbl[8]  = '{1'b1, apb_pkg::ADDR_DR,  8'h11, 0,   1'b1, 8'h00, 1'b1, 1'b0, 3};
        tbl[9]  = '{1'b0, apb_pkg::ADDR_DR,  8'h00, 0,   1'b0, 8'h9E, 1'b0, 1'b0, 3};
        tbl[10] = '{1'b1, apb_pkg::ADDR_CR2, 8'hFF, 100, 1'b0, 8'h00, 1'b1, 1'b1, 6};
        tbl[11] = '{1'b0, apb_pkg::ADDR_CR2, 8'h00, 0,   1'b0, 8'h00, 1'b0, 1'b0, 3};
        addr_set = '{apb_pkg::ADDR_CR1, apb_pkg::ADDR_CR2, apb_pkg::ADDR_BR,
                     apb_pkg::ADDR_SR, apb_pkg::ADDR_DR};
        // {PSEL, PENABLE, PREADY, rsp_valid, busy} for cycles 1..4 of a one-wait write
        tr_exp = '{5'b10001, 5'b11001, 5'b11101, 5'b00010};

        repeat (3) @(negedge Pclk);
        check("reset.outs", {15'd0, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err,
                             rsp_timeout, busy}, 32'd0);
        check("reset.rdata", 32'(rsp_rdata), 32'd0);
        Preset = 1'b0;

        slv_waits = 1; slv_tip = 1'b0;
        @(negedge Pclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = apb_pkg::ADDR_CR1; cmd_wdata = 8'h5C;
        @(posedge Pclk);
        #1 cmd_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Pclk);
            check($sformatf("seq1.c%0d", c + 1), 32'({PSEL, PENABLE, PREADY, rsp_valid, busy}),
                  32'(tr_exp[c]));
        end

        for (int i = 0; i < 12; i++)
            run_cmd($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].wt, tbl[i].tp,
                    tbl[i].rd, tbl[i].err, tbl[i].to, tbl[i].lat);

        // Back-to-back: write CR2 then read CR2 with cmd_valid held, zero-wait slave.
        slv_waits = 0; slv_tip = 1'b0;
        @(negedge Pclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = apb_pkg::ADDR_CR2; cmd_wdata = 8'h3A;
        @(posedge Pclk);
        #1 cmd_write = 1'b0; cmd_wdata = 8'h00;
        @(negedge Pclk);
        check("b2b.c1", 32'({PSEL, PENABLE, cmd_ready}), 32'b100);
        @(negedge Pclk);
        check("b2b.c2", 32'({PSEL, PENABLE, PREADY, cmd_ready}), 32'b1111);
        @(posedge Pclk);
        #1 cmd_valid = 1'b0;
        @(negedge Pclk);
        check("b2b.c3", 32'({PSEL, PENABLE, rsp_valid, rsp_err}), 32'b1010);
        @(negedge Pclk);
        check("b2b.c4", 32'({PSEL, PENABLE, rsp_valid}), 32'b110);
        @(negedge Pclk);
        check("b2b.c5", {22'd0, PSEL, rsp_valid, rsp_rdata}, {22'd0, 1'b0, 1'b1, 8'h3A});

        // Reset in the second wait cycle of ACCESS.
        slv_waits = 3;
        @(negedge Pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = apb_pkg::ADDR_BR;
        @(posedge Pclk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge Pclk);
        check("rst.pre", 32'({PSEL, PENABLE, busy}), 32'b111);
        Preset = 1'b1;
        #1 check("rst.async", 32'({PSEL, PENABLE, busy}), 32'b000);
        repeat (2) @(negedge Pclk);
        Preset = 1'b0;
        begin
            bit any_rsp = 1'b0;
            repeat (6) begin
                @(negedge Pclk);
                if (rsp_valid) any_rsp = 1'b1;
            end
            check("rst.norsp", 32'(any_rsp), 32'd0);
        end
        run_cmd("rst.wr", 1'b1, apb_pkg::ADDR_BR, 8'h42, 1, 1'b0, 8'h00, 1'b0, 1'b0, 4);
        run_cmd("rst.rd", 1'b0, apb_pkg::ADDR_BR, 8'h00, 1, 1'b0, 8'h42, 1'b0, 1'b0, 4);

        // TIMEOUT=3 instance: PREADY arrives in the third ACCESS cycle, completion wins.
        @(negedge Pclk);
        t3_cmd_valid = 1'b1; t3_cmd_write = 1'b0; t3_cmd_addr = apb_pkg::ADDR_SR;
        @(posedge Pclk);
        #1 t3_cmd_valid = 1'b0;
        @(negedge Pclk);
        check("t3.c1", 32'({t3_psel, t3_penable, t3_pwrite, t3_busy}), 32'b1001);
        repeat (3) @(negedge Pclk);
        check("t3.c4", 32'({t3_psel, t3_penable, t3_rsp_valid, t3_cmd_ready}), 32'b1100);
        t3_pready = 1'b1; t3_prdata = 8'h77;
        @(posedge Pclk);
        #1 t3_pready = 1'b0;
        @(negedge Pclk);
        check("t3.c5", {20'd0, t3_rsp_valid, t3_rsp_err, t3_rsp_timeout, t3_psel, t3_rsp_rdata},
              {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77});

        // Randomized commands against a transaction-level reference model.
        @(negedge Pclk);
        Preset = 1'b1;
        @(negedge Pclk);
        Preset = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
        for (int n = 0; n < 40; n++) begin
            bit         w, tp, e_err, e_to;
            logic [2:0] a;
            logic [7:0] d, e_rd;
            int         wt, e_lat;
            w  = 1'($urandom_range(0, 1));
            a  = addr_set[$urandom_range(0, 4)];
            d  = 8'($urandom);
            wt = $urandom_range(0, 5);
            tp = ($urandom_range(0, 3) == 0);
            if (wt >= TO) begin
                e_rd = 8'h00; e_err = 1'b1; e_to = 1'b1; e_lat = TO + 2;
            end else begin
                e_lat = 3 + wt;
                e_to  = 1'b0;
                e_err = tp && (a == apb_pkg::ADDR_DR);
                e_rd  = (!w && !e_err) ? ref_mem[a] : 8'h00;
                if (w && !e_err) ref_mem[a] = d;
            end
            run_cmd($sformatf("rnd%0d", n), w, a, d, wt, tp, e_rd, e_err, e_to, e_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the peripheral bus of the SPI IP core (register map CR1/CR2/BR/SR/DR) from a simple command/response interface.
- Converts one-beat command requests into compliant APB SETUP/ACCESS transfers.
- Tolerates any number of PREADY wait states and reports PSLVERR.
- Aborts hung transfers with a wait-state timeout.
- Sits between a test/CPU-side command source and the SPI core's APB slave port.

Parameters:
- ADDR_W, 3, APB address width (PADDR).
- DATA_W, 8, APB data width (PWDATA/PRDATA).
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables timeout.

Ports:
- Pclk  in  1  clock.
- Preset  in  1  reset; asynchronous assert, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a Pclk edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR seen or timeout, qualified by rsp_valid.
- rsp_timeout  out  1  abort due to timeout, qualified by rsp_valid.
- busy  out  1  high in SETUP or ACCESS.
- PSEL, PENABLE, PWRITE  out  1  APB controls.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY, PSLVERR  in  1  APB completion and error.

Behaviour:
- Reset: Preset high forces, immediately and asynchronously, state IDLE and all outputs 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_*, busy). Wait counter is cleared.
- State machine: IDLE (2'b00), SETUP (2'b01), ACCESS (2'b10). All APB outputs are registered.
- IDLE: cmd_ready=1. On accept, latch addr/write/wdata and go to SETUP.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA stay stable until completion.
- Completion: PREADY=1 in ACCESS.
  - PSLVERR is sampled only in the completion cycle.
  - Next cycle: rsp_valid=1 (registered); rsp_err=PSLVERR; rsp_rdata = PRDATA for a read with no error, else 0.
- cmd_ready is also 1 in ACCESS while PREADY=1. A command accepted then goes straight to SETUP with no IDLE cycle; PSEL stays high and PENABLE drops. Otherwise the block returns to IDLE with PSEL=0 and PENABLE=0.
- Latency, zero-wait slave: accept edge at cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3. Each wait state adds one cycle. The codebase's SPI APB slave inserts one wait state, so rsp_valid arrives in cycle 4.
- Timeout:
  - Counter increments every ACCESS cycle with PREADY=0 and clears on entering SETUP.
  - When the counter reaches TIMEOUT-1 and PREADY is still 0, the transfer is aborted. Next cycle: PSEL=PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Return to IDLE.
  - No command is accepted in the abort cycle.
  - PREADY=1 in the same cycle as the timeout: normal completion wins.
- Counter width is clog2(TIMEOUT+1). TIMEOUT=0: ACCESS waits indefinitely.
- rsp_* hold their values between pulses. rsp_valid is exactly one cycle per accepted command. There is no response backpressure.
- Reset mid-transfer: the bus returns to idle immediately and no rsp_valid is produced for the lost transfer.
- cmd_* inputs are ignored when cmd_ready=0.

Decomposition:
- Shared package apb_pkg:
  - APB state encoding constants: IDLE, SETUP, ACCESS.
  - SPI register address constants: CR1=3'b000, CR2=3'b001, BR=3'b010, SR=3'b011, DR=3'b101.
- One sub-module: apb_wait_timer, the parameterised wait counter with clear, count enable and expiry.

Test Plan:
- Write 0x5C to addr 0 against the SPI APB slave → PSEL rises in cycle 1, PENABLE in cycle 2, PREADY in cycle 3, rsp_valid in cycle 4 with rsp_err=0. A following read of addr 0 returns rsp_rdata=0x5C.
- Read addr 5 with slave tip=1 → PSLVERR=1 at completion; rsp_err=1, rsp_timeout=0, rsp_rdata=0x00.
- TIMEOUT=4, PREADY tied 0 → exactly 4 ACCESS cycles, then PSEL=PENABLE=0; rsp_valid with rsp_err=1, rsp_timeout=1.
- Two back-to-back commands (cmd_valid held, zero-wait model) → second SETUP directly follows first ACCESS with PSEL never low; two rsp_valid pulses 2 cycles apart.
- Preset asserted in the second wait cycle of ACCESS → PSEL, PENABLE and busy go 0 with no Pclk edge; no rsp_valid; next command after release completes normally.
- PREADY=1 in the same cycle as the timeout expiry (TIMEOUT=3, PREADY in the 3rd ACCESS cycle) → normal completion, rsp_timeout=0.
